// File: rtl/fix_msg_sched_pkg.sv
// Shared types and constants for the FIX field scheduler: FSM state encoding,
// protocol byte constants and the checksum-to-ASCII digit helper.
package fix_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TAG,
      S_VAL,
      S_GAP,
      S_CS_TAG,
      S_CS_VAL,
      S_DONE
   } state_e;

   localparam logic [7:0]  FIX_SOH        = 8'h01;
   localparam logic [7:0]  FIX_EQ         = 8'h3D;
   localparam logic [31:0] FIX_CSUM_TAG   = 32'h3031;
   localparam logic [4:0]  FIX_CSUM_TSIZE = 5'd2;

   // Hundreds digit lands in the lowest byte so it is serialized first.
   function automatic logic [23:0] csum_digits(input logic [7:0] c);
      logic [7:0] h;
      logic [7:0] t;
      logic [7:0] o;
      h = c / 8'd100;
      t = (c / 8'd10) % 8'd10;
      o = c % 8'd10;
      return {o + 8'h30, t + 8'h30, h + 8'h30};
   endfunction

endpackage

// File: rtl/fix_rr_arbiter.sv
// Pointer-based round-robin arbiter: searches from the index after i_ptr and
// returns a one-hot grant plus the encoded winner index.
module fix_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         i_req,
   input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
   output logic [NUM_REQ-1:0]         o_grant,
   output logic [$clog2(NUM_REQ)-1:0] o_idx
);

   localparam int IDX_W = $clog2(NUM_REQ);

   always_comb begin
      int j;
      logic found;
      j       = 0;
      found   = 1'b0;
      o_grant = '0;
      o_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         j = (int'(i_ptr) + i) % NUM_REQ;
         if (!found && i_req[j]) begin
            found      = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/fix_msg_sched.sv
// FIX field scheduler: locks one requester per message, sequences tag/value
// phases and, when FIX_SCHED_CHECKSUM_EN is defined, appends the 10=NNN trailer.
module fix_msg_sched
   import fix_pkg::*;
#(
   parameter int VALUE_WIDTH = 256,
   parameter int NUM_REQ     = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   input  logic [NUM_REQ-1:0]             req_last_i,
   input  logic [NUM_REQ*32-1:0]          req_tag_i,
   input  logic [NUM_REQ*5-1:0]           req_t_size_i,
   input  logic [NUM_REQ*VALUE_WIDTH-1:0] req_val_i,
   input  logic [NUM_REQ*8-1:0]           req_v_size_i,
   output logic [NUM_REQ-1:0]             grant_o,
   output logic                           tag_valid_o,
   output logic                           val_valid_o,
   output logic [31:0]                    tag_o,
   output logic [4:0]                     t_size_o,
   output logic [VALUE_WIDTH-1:0]         val_o,
   output logic [7:0]                     v_size_o,
   output logic                           checksum_o,
   input  logic                           done_i,
   input  logic [7:0]                     data_i,
   input  logic                           data_valid_i,
   output logic                           msg_done_o,
   output logic [$clog2(NUM_REQ)-1:0]     owner_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   state_e                 r_state;
   state_e                 w_next;
   logic [IDX_W-1:0]       r_owner;
   logic [IDX_W-1:0]       w_loadIdx;
   logic [IDX_W-1:0]       w_arbIdx;
   logic [NUM_REQ-1:0]     w_arbOneHot;
   logic [NUM_REQ-1:0]     r_grant;
   logic                   w_load;
   logic                   w_ownerValid;
   logic [31:0]            r_tag;
   logic [4:0]             r_tSize;
   logic [VALUE_WIDTH-1:0] r_val;
   logic [7:0]             r_vSize;
   logic                   r_last;

   fix_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .i_req   (req_valid_i),
      .i_ptr   (r_owner),
      .o_grant (w_arbOneHot),
      .o_idx   (w_arbIdx)
   );

   assign w_ownerValid = req_valid_i[r_owner];

   always_comb begin
      w_next    = r_state;
      w_load    = 1'b0;
      w_loadIdx = r_owner;
      case (r_state)
         S_IDLE: begin
            if (|w_arbOneHot) begin
               w_next    = S_TAG;
               w_load    = 1'b1;
               w_loadIdx = w_arbIdx;
            end
         end
         S_TAG: begin
            if (done_i) w_next = S_VAL;
         end
         S_VAL: begin
            if (done_i) begin
`ifdef FIX_SCHED_CHECKSUM_EN
               if (r_last) w_next = S_CS_TAG;
`else
               if (r_last) w_next = S_DONE;
`endif
               else if (w_ownerValid) begin
                  w_next = S_TAG;
                  w_load = 1'b1;
               end
               else w_next = S_GAP;
            end
         end
         // The lock is held here: only the current owner may resume the message.
         S_GAP: begin
            if (w_ownerValid) begin
               w_next = S_TAG;
               w_load = 1'b1;
            end
         end
         S_CS_TAG: begin
            if (done_i) w_next = S_CS_VAL;
         end
         S_CS_VAL: begin
            if (done_i) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_owner <= '0;
         r_grant <= '0;
      end else begin
         r_state <= w_next;
         r_grant <= '0;
         if (w_load) r_owner <= w_loadIdx;
         if (r_state == S_VAL && done_i) r_grant[r_owner] <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tag   <= '0;
         r_tSize <= '0;
         r_val   <= '0;
         r_vSize <= '0;
         r_last  <= 1'b0;
      end else if (w_load) begin
         r_tag   <= req_tag_i[int'(w_loadIdx)*32 +: 32];
         r_tSize <= req_t_size_i[int'(w_loadIdx)*5 +: 5];
         r_val   <= req_val_i[int'(w_loadIdx)*VALUE_WIDTH +: VALUE_WIDTH];
         r_vSize <= req_v_size_i[int'(w_loadIdx)*8 +: 8];
         r_last  <= req_last_i[w_loadIdx];
      end
   end

`ifdef FIX_SCHED_CHECKSUM_EN
   logic [7:0]  r_csum;
   logic [23:0] w_digits;

   // Only body bytes count; leaving GAP for CS_TAG freezes the sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_csum <= '0;
      end else if (r_state == S_IDLE && w_load) begin
         r_csum <= '0;
      end else if (data_valid_i &&
                   (r_state == S_TAG || r_state == S_VAL || r_state == S_GAP)) begin
         r_csum <= r_csum + data_i;
      end
   end

   assign w_digits = csum_digits(r_csum);
`else
   logic w_unused_tap;
   assign w_unused_tap = ^{data_i, data_valid_i};
`endif

   always_comb begin
      tag_valid_o = (r_state == S_TAG);
      val_valid_o = (r_state == S_VAL);
      checksum_o  = 1'b0;
      tag_o       = '0;
      t_size_o    = '0;
      val_o       = '0;
      v_size_o    = '0;
      if (r_state == S_TAG || r_state == S_VAL) begin
         tag_o    = r_tag;
         t_size_o = r_tSize;
         val_o    = r_val;
         v_size_o = r_vSize;
      end
`ifdef FIX_SCHED_CHECKSUM_EN
      if (r_state == S_CS_TAG || r_state == S_CS_VAL) begin
         tag_valid_o = (r_state == S_CS_TAG);
         val_valid_o = (r_state == S_CS_VAL);
         checksum_o  = 1'b1;
         tag_o       = FIX_CSUM_TAG;
         t_size_o    = FIX_CSUM_TSIZE;
         val_o       = {{(VALUE_WIDTH-24){1'b0}}, w_digits};
         v_size_o    = 8'd3;
      end
`endif
   end

   assign msg_done_o = (r_state == S_DONE);
   assign grant_o    = r_grant;
   assign owner_o    = r_owner;

endmodule

// File: tb/tb_fix_msg_sched.sv
// Directed self-checking bench for fix_msg_sched; trailer expectations are
// selected by FIX_SCHED_CHECKSUM_EN to match the build under test.
module tb_fix_msg_sched;

   localparam int VW = 256;
   localparam int NR = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   reqValid;
   logic [NR-1:0]   reqLast;
   logic [NR*32-1:0] reqTag;
   logic [NR*5-1:0] reqTSize;
   logic [NR*VW-1:0] reqVal;
   logic [NR*8-1:0] reqVSize;
   logic [NR-1:0]   grant;
   logic            tagValid;
   logic            valValid;
   logic [31:0]     tagOut;
   logic [4:0]      tSizeOut;
   logic [VW-1:0]   valOut;
   logic [7:0]      vSizeOut;
   logic            checksum;
   logic            done;
   logic [7:0]      data;
   logic            dataValid;
   logic            msgDone;
   logic [1:0]      owner;

   int testsRun    = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   fix_msg_sched #(.VALUE_WIDTH(VW), .NUM_REQ(NR)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (reqValid),
      .req_last_i   (reqLast),
      .req_tag_i    (reqTag),
      .req_t_size_i (reqTSize),
      .req_val_i    (reqVal),
      .req_v_size_i (reqVSize),
      .grant_o      (grant),
      .tag_valid_o  (tagValid),
      .val_valid_o  (valValid),
      .tag_o        (tagOut),
      .t_size_o     (tSizeOut),
      .val_o        (valOut),
      .v_size_o     (vSizeOut),
      .checksum_o   (checksum),
      .done_i       (done),
      .data_i       (data),
      .data_valid_i (dataValid),
      .msg_done_o   (msgDone),
      .owner_o      (owner)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseDone();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic setField(input int k, input logic [31:0] tag, input logic [4:0] ts,
                           input logic [VW-1:0] val, input logic [7:0] vs, input logic last);
      reqTag[k*32 +: 32]  = tag;
      reqTSize[k*5 +: 5]  = ts;
      reqVal[k*VW +: VW]  = val;
      reqVSize[k*8 +: 8]  = vs;
      reqLast[k]          = last;
      reqValid[k]         = 1'b1;
   endtask

   task automatic clearReq(input int k);
      reqValid[k] = 1'b0;
   endtask

   // Walks from the cycle after the last grant to the DONE cycle.
   task automatic finishMessage();
`ifdef FIX_SCHED_CHECKSUM_EN
      pulseDone();
      pulseDone();
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      testsRun++; if (grant !== 4'b0) begin testsFailed++; $display("[TB] FAIL reset_grant got=%0h exp=0", grant); end
      testsRun++; if (tagValid !== 1'b0 || valValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_strobes got=%0b%0b exp=00", tagValid, valValid); end
      testsRun++; if (msgDone !== 1'b0 || checksum !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_flags got=%0b%0b exp=00", msgDone, checksum); end
      testsRun++; if (owner !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_owner got=%0d exp=0", owner); end
      testsRun++; if (tagOut !== 32'h0 || valOut !== '0) begin testsFailed++; $display("[TB] FAIL reset_fields got=%0h/%0h exp=0/0", tagOut, valOut); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_field();
      setField(0, 32'h0000_3533, 5'd2, 256'h41, 8'd1, 1'b1);
      tick();
      testsRun++; if (tagValid !== 1'b1 || valValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_tag_strobe got=%0b%0b exp=10", tagValid, valValid); end
      testsRun++; if (tagOut !== 32'h3533 || tSizeOut !== 5'd2) begin testsFailed++; $display("[TB] FAIL single_tag got=%0h/%0d exp=3533/2", tagOut, tSizeOut); end
      dataValid = 1'b1;
      data = 8'h33; tick();
      data = 8'h35; tick();
      data = 8'h3D; pulseDone();
      testsRun++; if (valValid !== 1'b1 || tagValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_val_strobe got=%0b%0b exp=01", valValid, tagValid); end
      testsRun++; if (valOut !== 256'h41 || vSizeOut !== 8'd1) begin testsFailed++; $display("[TB] FAIL single_val got=%0h/%0d exp=41/1", valOut, vSizeOut); end
      data = 8'h41; tick();
      data = 8'h01;
      testsRun++; if (grant !== 4'b0) begin testsFailed++; $display("[TB] FAIL single_early_grant got=%0h exp=0", grant); end
      pulseDone();
      testsRun++; if (grant !== 4'b0001) begin testsFailed++; $display("[TB] FAIL single_grant got=%0h exp=1", grant); end
      clearReq(0);
      data = 8'h55;
`ifdef FIX_SCHED_CHECKSUM_EN
      testsRun++; if (tagValid !== 1'b1 || checksum !== 1'b1 || tagOut !== 32'h3031 || tSizeOut !== 5'd2) begin testsFailed++; $display("[TB] FAIL single_cs_tag got=%0b%0b/%0h/%0d exp=11/3031/2", tagValid, checksum, tagOut, tSizeOut); end
      pulseDone();
      testsRun++; if (valValid !== 1'b1 || checksum !== 1'b1 || valOut !== 256'h313332 || vSizeOut !== 8'd3) begin testsFailed++; $display("[TB] FAIL single_cs_val got=%0b%0b/%0h/%0d exp=11/313332/3", valValid, checksum, valOut, vSizeOut); end
      dataValid = 1'b0;
      testsRun++; if (msgDone !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_early_done got=%0b exp=0", msgDone); end
      pulseDone();
`else
      dataValid = 1'b0;
`endif
      testsRun++; if (msgDone !== 1'b1 || checksum !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_msg_done got=%0b/%0b exp=1/0", msgDone, checksum); end
      tick();
      testsRun++; if (msgDone !== 1'b0 || grant !== 4'b0) begin testsFailed++; $display("[TB] FAIL single_pulse_width got=%0b/%0h exp=0/0", msgDone, grant); end
   endtask

   task automatic test_contention();
      setField(1, 32'h0000_3134, 5'd2, 256'h4242, 8'd2, 1'b1);
      setField(2, 32'h0000_3235, 5'd2, 256'h43, 8'd1, 1'b1);
      tick();
      testsRun++; if (owner !== 2'd1 || tagOut !== 32'h3134) begin testsFailed++; $display("[TB] FAIL contention_first got=%0d/%0h exp=1/3134", owner, tagOut); end
      pulseDone();
      pulseDone();
      testsRun++; if (grant !== 4'b0010) begin testsFailed++; $display("[TB] FAIL contention_grant1 got=%0h exp=2", grant); end
      clearReq(1);
      finishMessage();
      testsRun++; if (msgDone !== 1'b1 || owner !== 2'd1) begin testsFailed++; $display("[TB] FAIL contention_done1 got=%0b/%0d exp=1/1", msgDone, owner); end
      tick();
      tick();
      testsRun++; if (owner !== 2'd2 || tagValid !== 1'b1 || tagOut !== 32'h3235) begin testsFailed++; $display("[TB] FAIL contention_second got=%0d/%0b/%0h exp=2/1/3235", owner, tagValid, tagOut); end
      pulseDone();
      pulseDone();
      testsRun++; if (grant !== 4'b0100) begin testsFailed++; $display("[TB] FAIL contention_grant2 got=%0h exp=4", grant); end
      clearReq(2);
      finishMessage();
      tick();
      testsRun++; if (owner !== 2'd2 || tagValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL contention_ptr got=%0d/%0b exp=2/0", owner, tagValid); end
   endtask

   task automatic test_lock_gap();
      setField(0, 32'h0000_3131, 5'd2, 256'h58, 8'd1, 1'b0);
      tick();
      testsRun++; if (owner !== 2'd0) begin testsFailed++; $display("[TB] FAIL gap_owner got=%0d exp=0", owner); end
      setField(3, 32'h0000_3934, 5'd2, 256'h5A, 8'd1, 1'b1);
      pulseDone();
      clearReq(0);
      pulseDone();
      testsRun++; if (grant !== 4'b0001 || tagValid !== 1'b0 || valValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL gap_enter got=%0h/%0b%0b exp=1/00", grant, tagValid, valValid); end
      for (int i = 0; i < 3; i++) begin
         tick();
         testsRun++; if (grant !== 4'b0 || tagValid !== 1'b0 || owner !== 2'd0) begin testsFailed++; $display("[TB] FAIL gap_hold cycle %0d got=%0h/%0b/%0d exp=0/0/0", i, grant, tagValid, owner); end
      end
      setField(0, 32'h0000_3535, 5'd2, 256'h59, 8'd1, 1'b1);
      tick();
      testsRun++; if (tagValid !== 1'b1 || tagOut !== 32'h3535 || owner !== 2'd0) begin testsFailed++; $display("[TB] FAIL gap_resume got=%0b/%0h/%0d exp=1/3535/0", tagValid, tagOut, owner); end
      pulseDone();
      pulseDone();
      testsRun++; if (grant !== 4'b0001) begin testsFailed++; $display("[TB] FAIL gap_last_grant got=%0h exp=1", grant); end
      clearReq(0);
      finishMessage();
      testsRun++; if (msgDone !== 1'b1) begin testsFailed++; $display("[TB] FAIL gap_msg_done got=%0b exp=1", msgDone); end
      tick();
      tick();
      testsRun++; if (owner !== 2'd3 || tagOut !== 32'h3934) begin testsFailed++; $display("[TB] FAIL gap_next_owner got=%0d/%0h exp=3/3934", owner, tagOut); end
      pulseDone();
      pulseDone();
      clearReq(3);
      finishMessage();
      tick();
   endtask

   task automatic test_back_to_back();
      setField(1, 32'h0000_3434, 5'd2, 256'h31, 8'd1, 1'b0);
      tick();
      pulseDone();
      setField(1, 32'h0036_3535, 5'd3, 256'h3332, 8'd2, 1'b1);
      pulseDone();
      testsRun++; if (grant !== 4'b0010 || tagValid !== 1'b1 || tagOut !== 32'h363535 || tSizeOut !== 5'd3) begin testsFailed++; $display("[TB] FAIL b2b_same_cycle got=%0h/%0b/%0h/%0d exp=2/1/363535/3", grant, tagValid, tagOut, tSizeOut); end
      pulseDone();
      testsRun++; if (valOut !== 256'h3332 || vSizeOut !== 8'd2) begin testsFailed++; $display("[TB] FAIL b2b_val got=%0h/%0d exp=3332/2", valOut, vSizeOut); end
      pulseDone();
      testsRun++; if (grant !== 4'b0010) begin testsFailed++; $display("[TB] FAIL b2b_grant2 got=%0h exp=2", grant); end
      clearReq(1);
      finishMessage();
      testsRun++; if (msgDone !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_msg_done got=%0b exp=1", msgDone); end
      tick();
   endtask

`ifdef FIX_SCHED_CHECKSUM_EN
   task automatic test_wrap();
      setField(2, 32'h0000_3939, 5'd2, 256'h30, 8'd1, 1'b1);
      tick();
      dataValid = 1'b1;
      data = 8'hFF; tick();
      data = 8'hFF; pulseDone();
      data = 8'h01; pulseDone();
      dataValid = 1'b0;
      clearReq(2);
      pulseDone();
      testsRun++; if (valOut !== 256'h353532 || checksum !== 1'b1) begin testsFailed++; $display("[TB] FAIL wrap_digits got=%0h/%0b exp=353532/1", valOut, checksum); end
      pulseDone();
      tick();
   endtask
`endif

   task automatic test_reset_mid_message();
      setField(3, 32'h0000_3838, 5'd2, 256'h51, 8'd1, 1'b1);
      tick();
      testsRun++; if (owner !== 2'd3) begin testsFailed++; $display("[TB] FAIL rstmid_owner got=%0d exp=3", owner); end
      pulseDone();
      testsRun++; if (valValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_in_val got=%0b exp=1", valValid); end
      clearReq(3);
      #2;
      rst = 1'b1;
      #1;
      testsRun++; if (valValid !== 1'b0 || tagValid !== 1'b0 || valOut !== '0 || owner !== 2'd0) begin testsFailed++; $display("[TB] FAIL rstmid_async got=%0b%0b/%0h/%0d exp=00/0/0", valValid, tagValid, valOut, owner); end
      done = 1'b1;
      tick();
      done = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         testsRun++; if (grant !== 4'b0 || msgDone !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_silent cycle %0d got=%0h/%0b exp=0/0", i, grant, msgDone); end
      end
      setField(0, 32'h0000_3030, 5'd2, 256'h30, 8'd1, 1'b1);
      setField(1, 32'h0000_3131, 5'd2, 256'h31, 8'd1, 1'b1);
      tick();
      testsRun++; if (owner !== 2'd1 || tagOut !== 32'h3131) begin testsFailed++; $display("[TB] FAIL rstmid_ptr got=%0d/%0h exp=1/3131", owner, tagOut); end
      pulseDone();
      pulseDone();
      clearReq(0);
      clearReq(1);
      finishMessage();
      tick();
   endtask

   initial begin
      reqValid  = '0;
      reqLast   = '0;
      reqTag    = '0;
      reqTSize  = '0;
      reqVal    = '0;
      reqVSize  = '0;
      done      = 1'b0;
      data      = 8'h00;
      dataValid = 1'b0;
      test_reset();
      test_single_field();
      test_contention();
      test_lock_gap();
      test_back_to_back();
`ifdef FIX_SCHED_CHECKSUM_EN
      test_wrap();
`endif
      test_reset_mid_message();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
